score_link_tx: RTL

SCORE_LINK_TX -- requirements
Module: score_link_tx

---
 rtl/game_link_pkg.sv | 35 +++
 rtl/uart_byte_tx.sv | 93 +++++++++
 rtl/score_link_tx.sv | 114 +++++++++++
 3 files changed

// File: rtl/game_link_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : game_link_pkg
// Description : Shared constants and types for the board-to-board game link.
//               Packet opcodes, packet length and the UART bit-level state
//               encoding live here, so the transmitter and a future receiver
//               agree on the wire format.
// Revision    : 1.0  initial release
// ============================================================================
package game_link_pkg;

    // Packet opcodes
    localparam logic [7:0] c_OPC_START = 8'h53;   // 'S' : peer clicked PLAY
    localparam logic [7:0] c_OPC_SCORE = 8'h43;   // 'C' : current score follows

    // Bytes per packet: OPCODE, DATA, CHECK
    localparam int c_PKT_BYTES = 3;

    // Bit-level serialiser states
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START_BIT = 2'd1,
        DATA_BITS = 2'd2,
        STOP_BIT  = 2'd3
    } tx_state_e;

    // Checksum byte closing every packet
    function automatic logic [7:0] pkt_check(input logic [7:0] opcode,
                                             input logic [7:0] data);
        return opcode ^ data;
    endfunction

endpackage : game_link_pkg
`default_nettype wire

// File: rtl/uart_byte_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : uart_byte_tx
// Description : 8N1 byte serialiser. A byte is accepted when i_valid and
//               o_ready are both high. o_ready is high in IDLE and in the last
//               cycle of a stop bit, so a byte offered at that point follows
//               with no idle gap on the line.
// Ports       : clk, rst      - clock, synchronous active-high reset
//               i_byte/i_valid - byte to send and its qualifier
//               o_txd         - serial line (idles high, registered)
//               o_ready       - byte accepted this cycle if i_valid
//               o_busy        - a frame is on the line
//               o_done        - last stop-bit cycle with nothing queued
// Revision    : 1.0  initial release
// ============================================================================
module uart_byte_tx
    import game_link_pkg::*;
#(
    parameter int BIT_CYCLES = 651
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] i_byte,
    input  logic       i_valid,
    output logic       o_txd,
    output logic       o_ready,
    output logic       o_busy,
    output logic       o_done
);

    localparam int              c_CW   = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(BIT_CYCLES - 1);

    tx_state_e       r_state, w_state_nxt;
    logic [c_CW-1:0] r_baud;
    logic [2:0]      r_bit;
    logic [7:0]      r_shift, w_shift_nxt;
    logic            r_txd, w_txd_nxt;
    logic            w_bit_end, w_load;

    assign w_bit_end = (r_baud == c_LAST);
    assign o_ready   = (r_state == IDLE) || ((r_state == STOP_BIT) && w_bit_end);
    assign w_load    = o_ready && i_valid;
    assign o_busy    = (r_state != IDLE);
    assign o_done    = (r_state == STOP_BIT) && w_bit_end && !i_valid;
    assign o_txd     = r_txd;

    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_txd_nxt   = 1'b1;
        case (r_state)
            IDLE:      if (i_valid) w_state_nxt = START_BIT;
            START_BIT: if (w_bit_end) w_state_nxt = DATA_BITS;
            DATA_BITS: begin
                if (w_bit_end) begin
                    w_shift_nxt = {1'b0, r_shift[7:1]};
                    if (r_bit == 3'd7) w_state_nxt = STOP_BIT;
                end
            end
            STOP_BIT:  if (w_bit_end) w_state_nxt = i_valid ? START_BIT : IDLE;
            default:   w_state_nxt = IDLE;
        endcase
        if (w_load) w_shift_nxt = i_byte;
        // The line level is registered from the next state so that txd
        // changes on exactly the same edge as the state and stays glitch-free.
        case (w_state_nxt)
            START_BIT: w_txd_nxt = 1'b0;
            DATA_BITS: w_txd_nxt = w_shift_nxt[0];
            default:   w_txd_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_baud  <= '0;
            r_bit   <= 3'd0;
            r_shift <= 8'd0;
            r_txd   <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_shift <= w_shift_nxt;
            r_txd   <= w_txd_nxt;
            r_baud  <= ((r_state == IDLE) || w_bit_end) ? '0 : r_baud + c_CW'(1);
            // 3-bit counter wraps 7 -> 0 on the last data bit
            if ((r_state == DATA_BITS) && w_bit_end) r_bit <= r_bit + 3'd1;
        end
    end

endmodule : uart_byte_tx
`default_nettype wire

// File: rtl/score_link_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : score_link_tx
// Description : Sends 3-byte game packets (OPCODE, DATA, OPCODE^DATA) to the
//               peer board over an 8N1 UART. Request pulses set pending flags
//               that are never dropped; repeated pulses of one kind merge.
//               A pending start packet always goes before a pending score.
// Ports       : pclk      - pixel clock (only clock)
//               rst       - synchronous active-high reset
//               start_req - pulse: send start packet
//               score_req - pulse: send score packet
//               score     - local score 0..99, sampled when packet launches
//               txd       - serial line, idles high
//               busy      - packet on the line
//               pkt_done  - one-cycle pulse after the final stop bit
// Revision    : 1.0  initial release
// ============================================================================
module score_link_tx
    import game_link_pkg::*;
#(
    parameter int CLK_HZ = 75_000_000,
    parameter int BAUD   = 115_200
) (
    input  logic       pclk,
    input  logic       rst,
    input  logic       start_req,
    input  logic       score_req,
    input  logic [6:0] score,
    output logic       txd,
    output logic       busy,
    output logic       pkt_done
);

    localparam int c_BIT_CYCLES = CLK_HZ / BAUD;

    logic       r_pend_start, r_pend_score;
    logic       r_active, r_pkt_done;
    logic [7:0] r_opcode, r_data;
    logic [1:0] r_idx;

    logic       w_tx_ready, w_tx_busy, w_tx_done;
    logic       w_launch, w_accept, w_last;
    logic [7:0] w_byte;

    // A new packet only launches once the serialiser has fully drained the
    // previous one, which leaves at least one idle-high cycle between packets.
    assign w_launch = !r_active && !w_tx_busy && (r_pend_start || r_pend_score);
    assign w_accept = r_active && w_tx_ready;
    assign w_last   = (r_idx == 2'(c_PKT_BYTES - 1));

    always_comb begin
        w_byte = pkt_check(r_opcode, r_data);
        case (r_idx)
            2'd0:    w_byte = r_opcode;
            2'd1:    w_byte = r_data;
            default: w_byte = pkt_check(r_opcode, r_data);
        endcase
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            r_pend_start <= 1'b0;
            r_pend_score <= 1'b0;
            r_active     <= 1'b0;
            r_pkt_done   <= 1'b0;
            r_opcode     <= 8'd0;
            r_data       <= 8'd0;
            r_idx        <= 2'd0;
        end else begin
            r_pkt_done <= w_tx_done;
            // A pulse in the launch cycle re-arms the flag rather than being
            // absorbed by the packet that is leaving now.
            r_pend_start <= start_req | (r_pend_start & ~w_launch);
            r_pend_score <= score_req | (r_pend_score & ~(w_launch & ~r_pend_start));
            if (w_launch) begin
                r_active <= 1'b1;
                r_idx    <= 2'd0;
                if (r_pend_start) begin
                    r_opcode <= c_OPC_START;
                    r_data   <= 8'd0;
                end else begin
                    r_opcode <= c_OPC_SCORE;
                    r_data   <= {1'b0, score};
                end
            end else if (w_accept) begin
                if (w_last) begin
                    r_active <= 1'b0;
                    r_idx    <= 2'd0;
                end else begin
                    r_idx <= r_idx + 2'd1;
                end
            end
        end
    end

    uart_byte_tx #(
        .BIT_CYCLES (c_BIT_CYCLES)
    ) u_uart_byte_tx (
        .clk     (pclk),
        .rst     (rst),
        .i_byte  (w_byte),
        .i_valid (r_active),
        .o_txd   (txd),
        .o_ready (w_tx_ready),
        .o_busy  (w_tx_busy),
        .o_done  (w_tx_done)
    );

    assign busy     = w_tx_busy;
    assign pkt_done = r_pkt_done;

endmodule : score_link_tx
`default_nettype wire
